// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if
//   Groups the requester-side bus of the round-robin mux arbiter.
//   req     : per-requester request, bit i = requester i
//   din     : per-requester data bit, bits 0..3 = mux inputs a..d
//   gnt     : one-hot (or all-zero) grant
//   s1, s0  : mux select, equal to the granted index
//   y       : registered mux output, qualified by y_valid
//   busy    : high while a grant is active
// Modports: slave = arbiter side, master = requester side.
interface rr_mux_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       y;
  logic       y_valid;
  logic       busy;

  modport slave (
    input  req, din,
    output gnt, s1, s0, y, y_valid, busy
  );

  modport master (
    output req, din,
    input  gnt, s1, s0, y, y_valid, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Four-requester round-robin arbiter driving a 4:1 mux. A granted
//   requester keeps the grant while it requests, for at most MAX_HOLD
//   data cycles; the next search then starts just after it.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_mux_arbiter_if.slave (req/din in, gnt/s1/s0/y/y_valid/busy out)
// Parameter:
//   MAX_HOLD : max consecutive data cycles per grant, 1..15
module rr_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic            clk,
  input logic            rst,
  rr_mux_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] GRANT  = 1'b1;
  localparam logic [3:0] HOLD_C = 4'(MAX_HOLD);

  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [1:0] win_q,   win_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic       y_q,     y_d;
  logic       yv_q,    yv_d;

  logic       in_grant_s;
  logic       data_s;
  logic       rel_s;
  logic       arb_s;
  logic [3:0] cnt_plus_s;
  logic [1:0] ptr_eff_s;
  logic [1:0] winner_s;

  // First requesting index found scanning start, start+1, ... mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  // Decode data/release/arbitration conditions for the current cycle.
  always_comb begin
    in_grant_s = (state_q == GRANT);
    cnt_plus_s = cnt_q + 4'd1;
    data_s     = in_grant_s && bus.req[win_q];
    // Release: holder dropped its request, or this data cycle uses up the budget.
    rel_s      = in_grant_s && (!bus.req[win_q] || (cnt_plus_s == HOLD_C));
    arb_s      = !in_grant_s || rel_s;
    // A release re-arbitrates in the same cycle, so search from the updated pointer.
    if (rel_s) begin
      ptr_eff_s = win_q + 2'd1;
    end else begin
      ptr_eff_s = ptr_q;
    end
    winner_s = rr_pick(bus.req, ptr_eff_s);
  end

  // Next-state computation for FSM, pointer, hold counter and outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_eff_s;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    y_d     = y_q;
    yv_d    = 1'b0;

    if (data_s) begin
      y_d   = bus.din[win_q];
      yv_d  = 1'b1;
      cnt_d = cnt_plus_s;
    end else begin
      y_d   = y_q;
      yv_d  = 1'b0;
    end

    if (arb_s) begin
      if (bus.req != 4'b0000) begin
        state_d = GRANT;
        win_d   = winner_s;
        cnt_d   = 4'd0;
        gnt_d   = 4'b0001 << winner_s;
        sel_d   = winner_s;
      end else begin
        // Select lines keep the last granted index while idle.
        state_d = IDLE;
        gnt_d   = 4'b0000;
        sel_d   = sel_q;
      end
    end else begin
      state_d = GRANT;
      gnt_d   = gnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.s1      = sel_q[1];
  assign bus.s0      = sel_q[0];
  assign bus.y       = y_q;
  assign bus.y_valid = yv_q;
  assign bus.busy    = (state_q == GRANT);

endmodule
